// File: rtl/eb_pkg.sv
// Shared definitions for the elastic skid buffer: state encodings and an
// occupancy decode used by the buffer and any checker bound to it.
package eb_pkg;

    typedef enum logic [1:0] {
        EB_EMPTY = 2'b00,
        EB_HALF  = 2'b01,
        EB_FULL  = 2'b10
    } eb_state_e;

    // Encoding 2'b11 is unreachable; it reports zero words held.
    function automatic logic [1:0] eb_occ_of(input eb_state_e st);
        case (st)
            EB_HALF: eb_occ_of = 2'd1;
            EB_FULL: eb_occ_of = 2'd2;
            default: eb_occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/eb_skid_buf.sv
// Two-entry skid buffer: fully registered req/ack/data toward the consumer,
// no combinational path from i_0_ack back to t_0_ack, one word per cycle.
module eb_skid_buf
    import eb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             t_0_req,
    output logic             t_0_ack,
    input  logic [WIDTH-1:0] t_0_data,
    output logic             i_0_req,
    input  logic             i_0_ack,
    output logic [WIDTH-1:0] i_0_data,
    output logic [1:0]       occ
);

    // Handshake: a word moves on a port in any cycle where its req and ack
    // are both high at the rising edge; req/data are never retracted by the
    // buffer while its req is high and ack is low.

    eb_state_e        state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             wen, ren;

    assign t_0_ack  = (state_q != EB_FULL);
    assign i_0_req  = (state_q != EB_EMPTY);
    assign i_0_data = main_q;
    assign occ      = eb_occ_of(state_q);

    assign wen = t_0_req && t_0_ack;
    assign ren = i_0_req && i_0_ack;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EB_EMPTY: begin
                if (wen) begin
                    state_d = EB_HALF;
                    main_d  = t_0_data;
                end
            end
            EB_HALF: begin
                if (wen && !ren) begin
                    state_d = EB_FULL;
                    skid_d  = t_0_data;
                end else if (ren && !wen) begin
                    state_d = EB_EMPTY;
                end else if (wen && ren) begin
                    main_d  = t_0_data;
                end
            end
            EB_FULL: begin
                // The skid word is older than anything still upstream.
                if (ren) begin
                    state_d = EB_HALF;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EB_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EB_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    a_no_wen_full: assert property (@(posedge clk) disable iff (!reset_n)
        !(wen && state_q == EB_FULL))
        else $error("eb_skid_buf: write accepted while full");

    a_no_ren_empty: assert property (@(posedge clk) disable iff (!reset_n)
        !(ren && state_q == EB_EMPTY))
        else $error("eb_skid_buf: read while empty");

    a_legal_state: assert property (@(posedge clk) disable iff (!reset_n)
        state_q != eb_state_e'(2'b11))
        else $error("eb_skid_buf: illegal state encoding");

    a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (i_0_req && !i_0_ack) |=> (i_0_req && $stable(i_0_data)))
        else $error("eb_skid_buf: output changed under stall");

    a_occ_count: assert property (@(posedge clk) disable iff (!reset_n)
        $past(reset_n) |->
            (occ == 2'($past(occ) + 2'($past(wen)) - 2'($past(ren)))))
        else $error("eb_skid_buf: occupancy disagrees with transfer count");

endmodule

// File: tb/tb_eb_skid_buf.sv
// Directed bench for eb_skid_buf: reset, single word, fill/stall, streaming,
// random backpressure against an expected queue, and mid-operation reset.
module tb_eb_skid_buf;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         t_0_req;
    logic         t_0_ack;
    logic [W-1:0] t_0_data;
    logic         i_0_req;
    logic         i_0_ack;
    logic [W-1:0] i_0_data;
    logic [1:0]   occ;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    eb_skid_buf #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .t_0_req  (t_0_req),
        .t_0_ack  (t_0_ack),
        .t_0_data (t_0_data),
        .i_0_req  (i_0_req),
        .i_0_ack  (i_0_ack),
        .i_0_data (i_0_data),
        .occ      (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs
    // sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " t_0_ack"}, W'(t_0_ack), 1);
        chk({tag, " i_0_req"}, W'(i_0_req), 0);
        chk({tag, " occ"}, W'(occ), 0);
        chk({tag, " i_0_data"}, i_0_data, 0);
    endtask

    initial begin
        int sent;
        int recvd;
        int cyc;
        logic [W-1:0] exp_w;

        reset_n  = 1'b0;
        t_0_req  = 1'b0;
        i_0_ack  = 1'b0;
        t_0_data = '0;

        // Reset then idle
        #1;
        chk_idle("in_reset_t0");
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("in_reset");
        end
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_idle("idle");
        end

        // Single word
        t_0_req  = 1'b1;
        t_0_data = 32'hA5A5_0001;
        step();
        t_0_req = 1'b0;
        chk("single i_0_req", W'(i_0_req), 1);
        chk("single i_0_data", i_0_data, 32'hA5A5_0001);
        chk("single occ", W'(occ), 1);
        i_0_ack = 1'b1;
        step();
        i_0_ack = 1'b0;
        chk("single drained occ", W'(occ), 0);
        chk("single drained i_0_req", W'(i_0_req), 0);

        // Fill and stall
        t_0_req  = 1'b1;
        t_0_data = 32'h11;
        step();
        chk("fill half occ", W'(occ), 1);
        t_0_data = 32'h22;
        step();
        t_0_req = 1'b0;
        chk("fill occ", W'(occ), 2);
        chk("fill t_0_ack", W'(t_0_ack), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall data", i_0_data, 32'h11);
            chk("stall occ", W'(occ), 2);
            chk("stall t_0_ack", W'(t_0_ack), 0);
        end
        i_0_ack = 1'b1;
        chk("release first", i_0_data, 32'h11);
        step();
        chk("release t_0_ack", W'(t_0_ack), 1);
        chk("release second", i_0_data, 32'h22);
        chk("release occ", W'(occ), 1);
        step();
        i_0_ack = 1'b0;
        chk("release empty occ", W'(occ), 0);

        // Streaming
        t_0_req = 1'b1;
        i_0_ack = 1'b1;
        for (int i = 0; i < 64; i++) begin
            t_0_data = W'(i);
            step();
            chk("stream data", i_0_data, W'(i));
            chk("stream i_0_req", W'(i_0_req), 1);
            chk("stream occ", W'(occ), 1);
            chk("stream t_0_ack", W'(t_0_ack), 1);
        end
        t_0_req = 1'b0;
        step();
        i_0_ack = 1'b0;
        chk("stream drained occ", W'(occ), 0);

        // Random backpressure against the expected queue
        sent  = 0;
        recvd = 0;
        cyc   = 0;
        t_0_data = 32'h1000_0000;
        while (recvd < 1000 && cyc < 20000) begin
            if (!(t_0_req && !t_0_ack)) begin
                t_0_req = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (t_0_req) t_0_data = 32'h1000_0000 + W'(sent);
            end
            i_0_ack = (cyc > 5000) ? 1'b1 : 1'($urandom_range(0, 1));
            #0;
            if (i_0_req && i_0_ack) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                chk("rand data", i_0_data, exp_w);
                recvd++;
            end
            if (t_0_req && t_0_ack) begin
                exp_q.push_back(t_0_data);
                sent++;
            end
            step();
            cyc++;
            checks++;
            assert (occ <= 2'd2)
            else begin
                errors++;
                $error("FAIL rand occ bound: observed %0d expected <= 2", occ);
            end
            chk("rand occ model", W'(occ), W'(exp_q.size()));
        end
        t_0_req = 1'b0;
        i_0_ack = 1'b0;
        chk("rand received", W'(recvd), 1000);
        chk("rand queue empty", W'(exp_q.size()), 0);

        // Mid-operation reset
        t_0_req  = 1'b1;
        t_0_data = 32'h33;
        step();
        t_0_data = 32'h44;
        step();
        t_0_req = 1'b0;
        chk("pre reset occ", W'(occ), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("async reset");
        step();
        chk_idle("async reset held");
        reset_n  = 1'b1;
        t_0_req  = 1'b1;
        t_0_data = 32'h55;
        step();
        t_0_req = 1'b0;
        chk("post reset i_0_req", W'(i_0_req), 1);
        chk("post reset data", i_0_data, 32'h55);
        chk("post reset occ", W'(occ), 1);
        i_0_ack = 1'b1;
        step();
        i_0_ack = 1'b0;
        chk("post reset drained occ", W'(occ), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
